// File: rtl/contador_mmss_param.sv
`default_nettype none
// ============================================================================
// Module      : contador_mmss_param
// Description : BCD countdown timer MM..M:SS with a parameterisable number
//               of minute digits. The timer is preset by load, started and
//               paused with start/stop, and decremented once per tick while
//               running. Expiry enters DONE and emits a one-cycle done pulse.
//               Optional +30 s feature enabled by macro CONTADOR_ADD30_EN.
// Ports       : clk      - clock, rising edge
//               clear    - asynchronous active-high reset
//               tick     - 1 Hz single-cycle strobe
//               load     - load preset digits (highest priority)
//               uni_sec  - preset units of seconds (BCD)
//               dez_sec  - preset tens of seconds (BCD)
//               min      - preset minute digits, LS digit in [3:0]
//               start    - run request
//               stop     - pause request
//               add30    - +30 s request (ignored unless CONTADOR_ADD30_EN)
//               count_us - current units of seconds
//               count_ds - current tens of seconds
//               count_m  - current minute digits
//               zero     - all digits zero (combinational)
//               running  - FSM in RUN
//               done     - one-cycle pulse on entry to DONE
// Revision    : 1.0 - initial release
// ============================================================================
module contador_mmss_param #(
    parameter int MIN_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    tick,
    input  logic                    load,
    input  logic [3:0]              uni_sec,
    input  logic [3:0]              dez_sec,
    input  logic [4*MIN_DIGITS-1:0] min,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    add30,
    output logic [3:0]              count_us,
    output logic [3:0]              count_ds,
    output logic [4*MIN_DIGITS-1:0] count_m,
    output logic                    zero,
    output logic                    running,
    output logic                    done
);

    localparam int         c_MW   = 4 * MIN_DIGITS;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [3:0]      r_us;
    logic [3:0]      r_ds;
    logic [c_MW-1:0] r_m;
    logic [1:0]      r_state;
    logic            r_done;

    logic            w_zero;
    logic [3:0]      w_load_us;
    logic [3:0]      w_load_ds;
    logic [c_MW-1:0] w_load_m;
    logic [3:0]      w_dec_us;
    logic [3:0]      w_dec_ds;
    logic [c_MW-1:0] w_dec_m;
    logic            w_dec_borrow;
    logic            w_dec_zero;
    logic            w_add30_go;
    logic [3:0]      w_add_us;
    logic [3:0]      w_add_ds;
    logic [c_MW-1:0] w_add_m;

    assign w_zero = (r_us == 4'd0) && (r_ds == 4'd0) && (r_m == '0);

    // Preset clamping: any digit above 9 becomes 9, tens of seconds above 5 become 5
    assign w_load_us = (uni_sec > 4'd9) ? 4'd9 : uni_sec;
    assign w_load_ds = (dez_sec > 4'd5) ? 4'd5 : dez_sec;

    generate
        for (genvar gi = 0; gi < MIN_DIGITS; gi++) begin : g_min_clamp
            assign w_load_m[gi*4 +: 4] = (min[gi*4 +: 4] > 4'd9) ? 4'd9 : min[gi*4 +: 4];
        end
    endgenerate

    // One-second decrement with base-10 / base-6 borrow rippling into minutes.
    // Only applied when the count is non-zero, so wrap-around never occurs.
    always_comb begin
        w_dec_us     = r_us;
        w_dec_ds     = r_ds;
        w_dec_m      = r_m;
        w_dec_borrow = 1'b0;
        if (r_us != 4'd0) begin
            w_dec_us = r_us - 4'd1;
        end else begin
            w_dec_us = 4'd9;
            if (r_ds != 4'd0) begin
                w_dec_ds = r_ds - 4'd1;
            end else begin
                w_dec_ds     = 4'd5;
                w_dec_borrow = 1'b1;
                for (int i = 0; i < MIN_DIGITS; i++) begin
                    if (w_dec_borrow) begin
                        if (r_m[i*4 +: 4] == 4'd0) begin
                            w_dec_m[i*4 +: 4] = 4'd9;
                        end else begin
                            w_dec_m[i*4 +: 4] = r_m[i*4 +: 4] - 4'd1;
                            w_dec_borrow      = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign w_dec_zero = (w_dec_us == 4'd0) && (w_dec_ds == 4'd0) && (w_dec_m == '0);

`ifdef CONTADOR_ADD30_EN
    logic [3:0] w_add_ds_sum;
    logic       w_add_carry;

    // +30 s: add 3 to the tens of seconds, carry into minutes, and saturate
    // to all-nines minutes with 5:9 seconds when the top minute digit overflows.
    always_comb begin
        w_add_ds_sum = r_ds + 4'd3;
        w_add_us     = r_us;
        w_add_ds     = w_add_ds_sum;
        w_add_m      = r_m;
        w_add_carry  = 1'b0;
        if (w_add_ds_sum >= 4'd6) begin
            w_add_ds    = w_add_ds_sum - 4'd6;
            w_add_carry = 1'b1;
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (w_add_carry) begin
                if (r_m[i*4 +: 4] == 4'd9) begin
                    w_add_m[i*4 +: 4] = 4'd0;
                end else begin
                    w_add_m[i*4 +: 4] = r_m[i*4 +: 4] + 4'd1;
                    w_add_carry       = 1'b0;
                end
            end
        end
        if (w_add_carry) begin
            w_add_us = 4'd9;
            w_add_ds = 4'd5;
            w_add_m  = {MIN_DIGITS{4'h9}};
        end
    end

    assign w_add30_go = add30 && ((r_state == c_IDLE) || (r_state == c_RUN));
`else
    // Feature disabled: the port stays on the boundary but drives nothing.
    logic w_unused_add30;
    assign w_unused_add30 = add30;
    assign w_add30_go     = 1'b0;
    assign w_add_us       = r_us;
    assign w_add_ds       = r_ds;
    assign w_add_m        = r_m;
`endif

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_us    <= 4'd0;
            r_ds    <= 4'd0;
            r_m     <= '0;
            r_state <= c_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_us    <= w_load_us;
                r_ds    <= w_load_ds;
                r_m     <= w_load_m;
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_add30_go) begin
                            r_us <= w_add_us;
                            r_ds <= w_add_ds;
                            r_m  <= w_add_m;
                            // quick-start from 0:00, or start alongside add30
                            if (w_zero || start) begin
                                r_state <= c_RUN;
                            end
                        end else if (start && !w_zero) begin
                            r_state <= c_RUN;
                        end
                    end
                    c_RUN: begin
                        if (w_add30_go) begin
                            // add30 takes the cycle; a coincident tick is dropped
                            r_us <= w_add_us;
                            r_ds <= w_add_ds;
                            r_m  <= w_add_m;
                            if (stop) begin
                                r_state <= c_IDLE;
                            end
                        end else if (tick && !w_zero) begin
                            r_us <= w_dec_us;
                            r_ds <= w_dec_ds;
                            r_m  <= w_dec_m;
                            // expiry wins over a coincident stop so done is never lost
                            if (w_dec_zero) begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                            end else if (stop) begin
                                r_state <= c_IDLE;
                            end
                        end else if (stop) begin
                            r_state <= c_IDLE;
                        end
                    end
                    c_DONE: begin
                        if (start) begin
                            r_state <= c_IDLE;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign count_us = r_us;
    assign count_ds = r_ds;
    assign count_m  = r_m;
    assign zero     = w_zero;
    assign running  = (r_state == c_RUN);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_contador_mmss_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_mmss_param
// Description : Directed self-checking bench for contador_mmss_param with
//               MIN_DIGITS=2. The count is compared as a packed BCD word
//               {minutes, tens, units}, e.g. 16'h0105 for 01:05.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_mmss_param;

    localparam int MIN_DIGITS = 2;

    logic        clk = 1'b0;
    logic        clear;
    logic        tick;
    logic        load;
    logic [3:0]  uni_sec;
    logic [3:0]  dez_sec;
    logic [7:0]  min;
    logic        start;
    logic        stop;
    logic        add30;
    logic [3:0]  count_us;
    logic [3:0]  count_ds;
    logic [7:0]  count_m;
    logic        zero;
    logic        running;
    logic        done;
    logic [15:0] w_time;

    int n_checks = 0;
    int n_errors = 0;

    contador_mmss_param #(.MIN_DIGITS(MIN_DIGITS)) u_dut (
        .clk      (clk),
        .clear    (clear),
        .tick     (tick),
        .load     (load),
        .uni_sec  (uni_sec),
        .dez_sec  (dez_sec),
        .min      (min),
        .start    (start),
        .stop     (stop),
        .add30    (add30),
        .count_us (count_us),
        .count_ds (count_ds),
        .count_m  (count_m),
        .zero     (zero),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign w_time = {count_m, count_ds, count_us};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [3:0] ds, input logic [3:0] us);
        min = m; dez_sec = ds; uni_sec = us; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_seq [6];
        exp_seq = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};

        clear = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; add30 = 1'b0;
        uni_sec = 4'd0; dez_sec = 4'd0; min = 8'd0;
        #12;
        check("reset_time",    32'(w_time),  32'h0000);
        check("reset_running", 32'(running), 32'd0);
        check("reset_done",    32'(done),    32'd0);
        check("reset_zero",    32'(zero),    32'd1);
        @(negedge clk);
        clear = 1'b0;

        // 1:05 countdown across the minute borrow
        do_load(8'h01, 4'd0, 4'd5);
        check("load_105", 32'(w_time), 32'h0105);
        check("load_105_idle", 32'(running), 32'd0);
        do_tick();
        check("idle_tick_held", 32'(w_time), 32'h0105);
        do_start();
        check("start_running", 32'(running), 32'd1);
        for (int i = 0; i < 6; i++) begin
            do_tick();
            check($sformatf("seq_%0d", i), 32'(w_time), 32'(exp_seq[i]));
        end
        check("no_tick_held", 32'(w_time), 32'h0059);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_idle", 32'(running), 32'd0);

        // clamping of out-of-range preset digits
        do_load(8'h0A, 4'd7, 4'hC);
        check("clamp_0959", 32'(w_time), 32'h0959);

        // start at zero ignored
        do_load(8'h00, 4'd0, 4'd0);
        do_start();
        check("start_zero_ignored", 32'(running), 32'd0);

        // expiry from 0:02
        do_load(8'h00, 4'd0, 4'd2);
        do_start();
        do_tick();
        check("exp_001", 32'(w_time), 32'h0001);
        check("exp_001_done", 32'(done), 32'd0);
        do_tick();
        check("exp_000", 32'(w_time), 32'h0000);
        check("exp_zero", 32'(zero), 32'd1);
        check("exp_done_pulse", 32'(done), 32'd1);
        check("exp_not_running", 32'(running), 32'd0);
        do_tick();
        check("exp_done_once", 32'(done), 32'd0);
        check("exp_held", 32'(w_time), 32'h0000);
        do_tick();
        check("exp_held2", 32'(w_time), 32'h0000);
        do_start();
        check("done_start_idle", 32'(running), 32'd0);

        // stop and tick together at 0:40
        do_load(8'h00, 4'd4, 4'd0);
        do_start();
        tick = 1'b1; stop = 1'b1; step(); tick = 1'b0; stop = 1'b0;
        check("stoptick_time", 32'(w_time), 32'h0039);
        check("stoptick_idle", 32'(running), 32'd0);
        do_tick();
        check("stoptick_held", 32'(w_time), 32'h0039);

        // 10:00 borrow through both minute digits
        do_load(8'h10, 4'd0, 4'd0);
        do_start();
        do_tick();
        check("borrow_1000", 32'(w_time), 32'h0959);

        // load has priority over tick/start/stop while running
        tick = 1'b1; start = 1'b1; stop = 1'b1;
        do_load(8'h25, 4'd3, 4'd3);
        tick = 1'b0; start = 1'b0; stop = 1'b0;
        check("load_prio_time", 32'(w_time), 32'h2533);
        check("load_prio_idle", 32'(running), 32'd0);

        // asynchronous clear mid-run at 3:21
        do_load(8'h03, 4'd2, 4'd2);
        do_start();
        do_tick();
        check("pre_clear", 32'(w_time), 32'h0321);
        #3;
        clear = 1'b1;
        #1;
        check("async_clear_time", 32'(w_time), 32'h0000);
        check("async_clear_run",  32'(running), 32'd0);
        check("async_clear_done", 32'(done), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        do_tick();
        check("post_clear_done", 32'(done), 32'd0);
        check("post_clear_time", 32'(w_time), 32'h0000);

`ifdef CONTADOR_ADD30_EN
        add30 = 1'b1; step(); add30 = 1'b0;
        check("add30_quick_time", 32'(w_time), 32'h0030);
        check("add30_quick_run", 32'(running), 32'd1);
        tick = 1'b1; add30 = 1'b1; step(); tick = 1'b0; add30 = 1'b0;
        check("add30_tick_suppr", 32'(w_time), 32'h0100);
        do_load(8'h99, 4'd4, 4'd5);
        add30 = 1'b1; step(); add30 = 1'b0;
        check("add30_saturate", 32'(w_time), 32'h9959);
        check("add30_nonzero_idle", 32'(running), 32'd0);
`else
        add30 = 1'b1; step(); add30 = 1'b0;
        check("add30_off_time", 32'(w_time), 32'h0000);
        check("add30_off_run", 32'(running), 32'd0);
        do_load(8'h01, 4'd0, 4'd0);
        do_start();
        tick = 1'b1; add30 = 1'b1; step(); tick = 1'b0; add30 = 1'b0;
        check("add30_off_tick", 32'(w_time), 32'h0059);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
